// File: rtl/rgb_pkg.sv
// rgb_pkg: shared types and constants for the RGB PWM driver.
//   COLOR_W       bits per colour channel (8)
//   PWM_LAST      last step value of a PWM frame (frame = 255 steps)
//   R/G/B_MSB/LSB field positions inside the 24-bit light word
//   color_t       one colour channel
//   gamma8()      approximate square-law gamma, used when RGB_GAMMA_EN is defined
package rgb_pkg;

  localparam int unsigned COLOR_W = 8;

  typedef logic [COLOR_W-1:0] color_t;

  localparam color_t PWM_LAST = 8'd254;

  localparam int unsigned R_MSB = 23;
  localparam int unsigned R_LSB = 16;
  localparam int unsigned G_MSB = 15;
  localparam int unsigned G_LSB = 8;
  localparam int unsigned B_MSB = 7;
  localparam int unsigned B_LSB = 0;

  // (x*(x+1))>>8 maps 0->0 and 255->255 exactly; 16 bits cannot overflow.
  function automatic color_t gamma8(input color_t x);
    logic [15:0] w_prod;
    w_prod = {8'd0, x} * ({8'd0, x} + 16'd1);
    return w_prod[15:8];
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// pwm_channel: one colour channel of the RGB PWM driver.
// Holds the double-buffered duty register and the registered compare output.
//   clk, rst  clock, asynchronous active-high reset
//   enable    0 forces the output low on the next edge
//   load      capture din into the duty register this edge
//   din       new duty value
//   cnt       shared step counter (0..254)
//   pwm       registered drive: enable && (cnt < duty)
module pwm_channel
  import rgb_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   enable,
  input  logic   load,
  input  color_t din,
  input  color_t cnt,
  output logic   pwm
);

  color_t r_duty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_duty <= '0;
      pwm    <= 1'b0;
    end else begin
      if (load) begin
        r_duty <= din;
      end
      // Compares against the duty in force before any load on this edge, so
      // the wrap edge still finishes the old frame's last step.
      pwm <= enable && (cnt < r_duty);
    end
  end

endmodule

// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver: converts a 24-bit colour word into three frame-synchronous
// PWM outputs with per-frame double-buffered duty values.
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   light        R=[23:16], G=[15:8], B=[7:0]
//   enable       1 = run; 0 = hold counters at zero, outputs low, track light
//   pwm_r/g/b    registered PWM drives
//   frame_start  one-cycle pulse in the first cycle (cnt==0) of each frame
// Build option: define RGB_GAMMA_EN to load gamma8(field) instead of the raw field.
module rgb_pwm_driver
  import rgb_pkg::*;
#(
  parameter int unsigned PRESCALE = 4,
  parameter int unsigned COLOR_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3*COLOR_W-1:0]   light,
  input  logic                   enable,
  output logic                   pwm_r,
  output logic                   pwm_g,
  output logic                   pwm_b,
  output logic                   frame_start
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] r_presc;
  color_t        r_cnt;
  logic          w_tick;
  logic          w_wrap;
  logic          w_load;
  color_t        w_din_r;
  color_t        w_din_g;
  color_t        w_din_b;

  assign w_tick = (r_presc == PW'(PRESCALE - 1));
  assign w_wrap = enable && w_tick && (r_cnt == PWM_LAST);
  // While disabled the duty registers follow light, so re-enabling starts a
  // frame with the latest colour already loaded.
  assign w_load = w_wrap || !enable;

`ifdef RGB_GAMMA_EN
  assign w_din_r = gamma8(light[R_MSB:R_LSB]);
  assign w_din_g = gamma8(light[G_MSB:G_LSB]);
  assign w_din_b = gamma8(light[B_MSB:B_LSB]);
`else
  assign w_din_r = light[R_MSB:R_LSB];
  assign w_din_g = light[G_MSB:G_LSB];
  assign w_din_b = light[B_MSB:B_LSB];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc     <= '0;
      r_cnt       <= '0;
      frame_start <= 1'b0;
    end else if (!enable) begin
      r_presc     <= '0;
      r_cnt       <= '0;
      frame_start <= 1'b0;
    end else begin
      r_presc     <= w_tick ? '0 : r_presc + 1'b1;
      if (w_wrap) begin
        r_cnt <= '0;
      end else if (w_tick) begin
        r_cnt <= r_cnt + 8'd1;
      end
      frame_start <= w_wrap;
    end
  end

  pwm_channel u_ch_r (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .load   (w_load),
    .din    (w_din_r),
    .cnt    (r_cnt),
    .pwm    (pwm_r)
  );

  pwm_channel u_ch_g (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .load   (w_load),
    .din    (w_din_g),
    .cnt    (r_cnt),
    .pwm    (pwm_g)
  );

  pwm_channel u_ch_b (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .load   (w_load),
    .din    (w_din_b),
    .cnt    (r_cnt),
    .pwm    (pwm_b)
  );

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// tb_rgb_pwm_driver: scoreboard bench for rgb_pwm_driver with PRESCALE=2.
// The stimulus pushes the expected high-cycle counts of a frame when that
// frame begins; a negedge monitor checks every sample of the frame window and
// the window length, and pops the entry when the next frame_start arrives.
module tb_rgb_pwm_driver;

  localparam int unsigned PRESC = 2;
  localparam int          FRAME = 510;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [23:0] light;
  logic        pwm_r, pwm_g, pwm_b, frame_start;

  rgb_pwm_driver #(.PRESCALE(PRESC), .COLOR_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .light       (light),
    .enable      (enable),
    .pwm_r       (pwm_r),
    .pwm_g       (pwm_g),
    .pwm_b       (pwm_b),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int r;
    int g;
    int b;
  } exp_t;

  exp_t sb_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Hand-computed duty for each colour value used in the frame checks.
  function automatic int duty_of(input logic [7:0] x);
`ifdef RGB_GAMMA_EN
    case (x)
      8'h00:   return 0;
      8'h40:   return 16;
      8'h80:   return 64;
      8'hFF:   return 255;
      default: return -1;
    endcase
`else
    return int'(x);
`endif
  endfunction

  task automatic push_exp(input logic [23:0] l);
    exp_t e;
    e.r = int'(PRESC) * duty_of(l[23:16]);
    e.g = int'(PRESC) * duty_of(l[15:8]);
    e.b = int'(PRESC) * duty_of(l[7:0]);
    sb_q.push_back(e);
  endtask

  task automatic wait_fs(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!frame_start && n < 700);
    if (!frame_start) begin
      checks++;
      errors++;
      $display("FAIL fs_timeout: got no frame_start within %0d cycles", n);
    end
  endtask

  // Monitor: window sample k (1-based, k=1 is the cycle after the frame's
  // first cycle) must be high exactly when k <= expected high count.
  logic prev_act = 1'b0;
  bit   armed    = 1'b0;
  int   k, mis_r, mis_g, mis_b;
  exp_t cur;

  always @(negedge clk) begin
    logic act;
    act = enable && !rst;
    if (!act) begin
      armed = 1'b0;
    end else begin
      if (armed) begin
        k++;
        if (pwm_r != (k <= cur.r)) mis_r++;
        if (pwm_g != (k <= cur.g)) mis_g++;
        if (pwm_b != (k <= cur.b)) mis_b++;
      end
      if (frame_start || !prev_act) begin
        if (armed && frame_start) begin
          void'(sb_q.pop_front());
          chk("frame_len", k, FRAME);
          chk("frame_r_bad_samples", mis_r, 0);
          chk("frame_g_bad_samples", mis_g, 0);
          chk("frame_b_bad_samples", mis_b, 0);
        end
        armed = (sb_q.size() > 0);
        if (armed) cur = sb_q[0];
        k = 0; mis_r = 0; mis_g = 0; mis_b = 0;
      end
    end
    prev_act = act;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; enable = 1'b1; light = 24'hFFFFFF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pwm_r", pwm_r, 0);
    chk("rst_pwm_g", pwm_g, 0);
    chk("rst_pwm_b", pwm_b, 0);
    chk("rst_frame_start", frame_start, 0);

    // First frame after reset runs with duty 0 until the wrap loads light.
    rst = 1'b0;
    push_exp(24'h000000);
    wait_fs(n); chk("first_fs_delay", n, FRAME);
    push_exp(24'hFFFFFF); light = 24'h0000FF;
    wait_fs(n); chk("fs_period", n, FRAME);
    push_exp(24'h0000FF); light = 24'h804000;
    wait_fs(n);
    push_exp(24'h804000); light = 24'hFF0000;
    wait_fs(n);
    push_exp(24'hFF0000);
    repeat (100) @(posedge clk);
    #1 light = 24'h00FF00;
    wait_fs(n);
    push_exp(24'h00FF00);
    wait_fs(n);

    // Drop enable mid-frame.
    repeat (50) @(posedge clk);
    #1;
    chk("pre_disable_pwm_g", pwm_g, 1);
    enable = 1'b0;
    @(posedge clk); #1;
    chk("dis_pwm_r", pwm_r, 0);
    chk("dis_pwm_g", pwm_g, 0);
    chk("dis_pwm_b", pwm_b, 0);
    chk("dis_frame_start", frame_start, 0);
    chk("dis_cnt", int'(dut.r_cnt), 0);
    chk("dis_presc", int'(dut.r_presc), 0);
    light = 24'h123456;
    repeat (5) @(posedge clk);
    #1 light = 24'h00FF80;
    repeat (3) @(posedge clk);
    #1 enable = 1'b1;
    push_exp(24'h00FF80);
    wait_fs(n); chk("reenable_fs_delay", n, FRAME);

    // Asynchronous reset pulse at cnt=100.
    repeat (200) @(posedge clk);
    #1;
    chk("pre_rst_cnt", int'(dut.r_cnt), 100);
    chk("pre_rst_pwm_g", pwm_g, 1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_pwm_r", pwm_r, 0);
    chk("async_rst_pwm_g", pwm_g, 0);
    chk("async_rst_pwm_b", pwm_b, 0);
    chk("async_rst_cnt", int'(dut.r_cnt), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hold_frame_start", frame_start, 0);
    rst = 1'b0;
    push_exp(24'h000000);
    wait_fs(n); chk("post_rst_fs_delay", n, FRAME);
    push_exp(24'h00FF80);
    wait_fs(n); chk("final_fs_period", n, FRAME);
    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgb_pwm_driver.md
Name: rgb_pwm_driver

Overview:
Downstream consumer of the lights selector's 24-bit `light` word. It converts the three 8-bit colour fields into three frame-synchronous PWM outputs for a physical RGB LED. Duty values are double-buffered so a colour change never produces a torn frame. A `frame_start` strobe marks each PWM frame boundary.

Parameters:
PRESCALE, 4, clk cycles per PWM step; legal range >=1.
COLOR_W, 8, bits per colour channel; fixed at 8 in this revision.

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
light  input  24  colour from the selector: R=[23:16], G=[15:8], B=[7:0]
enable  input  1  1 = drive LEDs; 0 = hold counters in reset state, outputs low
pwm_r  output  1  red PWM drive, registered
pwm_g  output  1  green PWM drive, registered
pwm_b  output  1  blue PWM drive, registered
frame_start  output  1  one-cycle pulse on the first cycle of each PWM frame

Behaviour:
- Clocking and reset: single clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values: pwm_r/g/b=0, frame_start=0, presc=0, cnt=0, duty_r/g/b=0. Reset takes effect immediately, including mid-frame.
- Prescaler: presc counts 0..PRESCALE-1. tick=1 when presc==PRESCALE-1, then presc wraps to 0. With PRESCALE=1, tick=1 every cycle.
- Step counter: cnt is 8 bits. On each tick it increments, and wraps 254 -> 0. Frame length = 255 steps = 255*PRESCALE cycles.
- Frame boundary: wrap = tick && cnt==254.
  - On the wrap edge, duty_x loads the matching field of `light`.
  - On the same edge, frame_start is registered high for exactly one cycle, the cycle in which cnt==0.
- Mid-frame isolation: `light` changes away from a wrap edge have no effect until the next wrap.
- Compare: on every edge, pwm_x <= enable && (cnt < duty_x). Latency is 1 cycle from cnt/duty to output.
  - duty=0 -> output never high.
  - duty=255 -> output always high (cnt never reaches 255).
  - duty=N -> N*PRESCALE high cycles per frame.
- enable=0:
  - presc=0, cnt=0, frame_start=0, pwm_x=0 (registered, so low after 1 cycle).
  - duty_x loads `light` every cycle.
- enable 0->1: the first enabled cycle starts a frame with cnt=0 and the latest `light` already loaded. No frame_start pulse is generated for this frame; the first pulse comes at the next wrap.
- Simultaneous wrap and `light` change: the value present at the wrap edge is the one captured.
- No arithmetic overflow is possible: cnt never exceeds 254, and presc never exceeds PRESCALE-1.

Optional Feature:
Macro: RGB_GAMMA_EN.
- Defined: duty_x loads gamma(x) = (x*(x+1))>>8, computed with 16-bit intermediates.
  - Examples: 0->0, 64->16, 128->64, 255->255.
  - Applies both at wrap loads and during enable=0 tracking.
- Undefined: duty_x loads the raw field x. The port list and timing are identical in both builds.

Decomposition:
- Package rgb_pkg:
  - COLOR_W=8, PWM_LAST=8'd254.
  - Field index constants R_MSB/R_LSB, G_MSB/G_LSB, B_MSB/B_LSB.
  - A typedef for an 8-bit colour channel.
  - Function gamma8(), used only under RGB_GAMMA_EN.
- Sub-module pwm_channel, instantiated 3x. Inputs: clk, rst, enable, load, din[7:0], cnt[7:0]. Output: pwm. It holds the duty register and the compare flop.
- Top level holds the prescaler, step counter, wrap/frame_start logic and field slicing.

Test Plan (PRESCALE=2, frame=510 cycles):
1. Assert rst, release, enable=1, light=24'hFFFFFF -> outputs 0 during reset. After the first wrap, pwm_r/g/b stay high for all 510 cycles of each frame. frame_start pulses every 510 cycles.
2. light=24'h0000FF -> after the next frame_start: pwm_r=pwm_g=0 throughout, pwm_b=1 throughout.
3. light=24'h804000 -> per frame, pwm_r high 256 cycles, pwm_g high 128 cycles, pwm_b 0. Each high run is contiguous from frame start. With RGB_GAMMA_EN: pwm_r high 128 cycles, pwm_g high 32 cycles.
4. Change light 24'hFF0000 -> 24'h00FF00 at cycle 100 of a frame -> pwm_r stays high and pwm_g stays low until the next frame_start; then they swap.
5. Drop enable mid-frame -> pwm_x=0 one cycle later and cnt=0. Re-raise enable -> new frame with the current light; the first frame_start arrives 510 cycles later.
6. Pulse rst for 3 cycles at cnt=100 -> outputs drop immediately (async). After release, the sequence restarts from cnt=0 with duty=0 until the first wrap loads `light`.
